// File: rtl/adv7393_pixel_serializer_if.sv
// Port bundle for the ADV7393 pixel serializer: line control, symbol stream in, 4:2:2 bytes out.
// master = symbol/line source, slave = serializer.
interface adv7393_pixel_serializer_if #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 12
);
  logic [LEN_W-1:0]  line_len;
  logic              line_start;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        pix_data;
  logic              pix_de;
  logic              line_done;
  logic              underflow;
  logic              underflow_clr;

  modport master (
    output line_len, line_start, s_data, s_valid, underflow_clr,
    input  s_ready, pix_data, pix_de, line_done, underflow
  );

  modport slave (
    input  line_len, line_start, s_data, s_valid, underflow_clr,
    output s_ready, pix_data, pix_de, line_done, underflow
  );
endinterface

// File: rtl/adv7393_pixel_serializer.sv
// Serializes multi-pixel YCbCr symbols into the ADV7393 8-bit 4:2:2 byte stream, one byte per clock.
//   state     | meaning
//   ST_IDLE   | no line in progress; blank Y byte driven, H may prefetch the next symbol
//   ST_ACTIVE | shifting bytes of S out; H reloads S at each symbol boundary
module adv7393_pixel_serializer #(
  parameter int PIXELS_PER_SYMBOL = 4,
  parameter int DATA_W            = 64,
  parameter int LEN_W             = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  adv7393_pixel_serializer_if.slave  bus
);

  localparam int                BYTES     = 2 * PIXELS_PER_SYMBOL;
  localparam int                BIDX_W    = $clog2(BYTES);
  localparam logic [DATA_W-1:0] BLANK_SYM = {PIXELS_PER_SYMBOL{16'h1080}};
  localparam logic [7:0]        Y_BLANK   = 8'h10;
  localparam logic [LEN_W:0]    REM_ONE   = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_MASK  = {{(LEN_W-2){1'b1}}, 2'b00};

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] h_q;
  logic              h_full_q;
  logic              h_full_d;
  logic [DATA_W-1:0] sh_q;
  logic              blank_q;
  logic [LEN_W:0]    rem_q;
  logic [7:0]        pix_data_q;
  logic              pix_de_q;
  logic              line_done_q;
  logic              underflow_q;
  logic              underflow_d;

  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W:0]    last_byte;
  logic              accept;
  logic              line_end;
  logic              boundary;
  logic              can_start;
  logic              start;
  logic              zero_start;
  logic              load;
  logic              take;
  logic [DATA_W-1:0] src;

  // rem_q counts down the bytes still to follow the one on pix_data; zero marks the last byte.
  // The edge that retires the last byte also accepts a new line_start, so lines can abut.
  always_comb begin
    len_eff     = bus.line_len & LEN_MASK;
    last_byte   = {len_eff, 1'b0} - REM_ONE;
    accept      = bus.s_valid && !h_full_q;
    line_end    = (state_q == ST_ACTIVE) && (rem_q == '0);
    boundary    = (state_q == ST_ACTIVE) && (rem_q[BIDX_W-1:0] == '0);
    can_start   = (state_q == ST_IDLE) || line_end;
    start       = can_start && bus.line_start && (len_eff != '0);
    zero_start  = can_start && bus.line_start && (len_eff == '0);
    load        = start || (boundary && !line_end);
    take        = load && h_full_q;
    src         = h_full_q ? h_q : BLANK_SYM;
    h_full_d    = (h_full_q && !take) || accept;
    underflow_d = (load && !h_full_q) || (underflow_q && !bus.underflow_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      h_q         <= '0;
      h_full_q    <= 1'b0;
      sh_q        <= '0;
      blank_q     <= 1'b0;
      rem_q       <= '0;
      pix_data_q  <= Y_BLANK;
      pix_de_q    <= 1'b0;
      line_done_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (accept) begin
        h_q <= bus.s_data;
      end
      h_full_q    <= h_full_d;
      underflow_q <= underflow_d;
      line_done_q <= line_end || zero_start;

      if (load) begin
        // Byte 0 goes straight from the source; the rest queue up in S.
        state_q    <= ST_ACTIVE;
        sh_q       <= src >> 8;
        blank_q    <= !h_full_q;
        pix_data_q <= src[7:0];
        pix_de_q   <= h_full_q;
        rem_q      <= start ? last_byte : rem_q - REM_ONE;
      end else if ((state_q == ST_ACTIVE) && !line_end) begin
        sh_q       <= sh_q >> 8;
        pix_data_q <= sh_q[7:0];
        pix_de_q   <= !blank_q;
        rem_q      <= rem_q - REM_ONE;
      end else begin
        state_q    <= ST_IDLE;
        pix_data_q <= Y_BLANK;
        pix_de_q   <= 1'b0;
      end
    end
  end

  assign bus.s_ready   = !h_full_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_de    = pix_de_q;
  assign bus.line_done = line_done_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_adv7393_pixel_serializer.sv
// Directed self-checking bench for adv7393_pixel_serializer.
module tb_adv7393_pixel_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   acc_cnt;
  int   sk;
  logic stream_on;

  adv7393_pixel_serializer_if #(.DATA_W(64), .LEN_W(12)) bus ();

  adv7393_pixel_serializer #(
    .PIXELS_PER_SYMBOL(4),
    .DATA_W(64),
    .LEN_W(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sym_f(input int k);
    logic [15:0] a;
    a = 16'(k);
    return {a ^ 16'hC3A5, ~a, a + 16'h0101, a};
  endfunction

  // Advance to the next falling edge, recording whether the rising edge in between accepted a symbol.
  task automatic tick();
    logic acc;
    acc = bus.s_valid && bus.s_ready;
    @(negedge clk);
    if (acc) begin
      acc_cnt++;
      if (stream_on) begin
        sk++;
        bus.s_data = sym_f(sk);
      end
    end
  endtask

  logic [7:0]  pf_exp [8];
  logic [7:0]  l7_exp [8];
  logic [63:0] tmp;
  logic [7:0]  expb;
  int          de_cnt;
  int          errs;
  int          bad;

  initial begin
    pf_exp = '{8'h44, 8'h11, 8'h33, 8'h22, 8'h22, 8'h33, 8'h11, 8'h44};
    l7_exp = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    checks = 0; failures = 0; acc_cnt = 0; sk = 0; stream_on = 1'b0;
    rst = 1'b1;
    bus.line_len = '0; bus.line_start = 1'b0; bus.s_data = '0;
    bus.s_valid = 1'b0; bus.underflow_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pix_data", 64'(bus.pix_data), 64'h10);
    chk("rst_pix_de", 64'(bus.pix_de), 64'h0);
    chk("rst_line_done", 64'(bus.line_done), 64'h0);
    chk("rst_underflow", 64'(bus.underflow), 64'h0);
    rst = 1'b0;
    tick();
    chk("rst_s_ready", 64'(bus.s_ready), 64'h1);
    chk("rst_idle_de", 64'(bus.pix_de), 64'h0);

    // Prefetched symbol, 4-pixel line
    bus.s_data = 64'h4411_3322_2233_1144; bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    chk("pf_h_full", 64'(bus.s_ready), 64'h0);
    bus.line_len = 12'd4; bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    chk("pf_h_taken", 64'(bus.s_ready), 64'h1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pf_byte%0d", i), 64'(bus.pix_data), 64'(pf_exp[i]));
      chk($sformatf("pf_de%0d", i), 64'(bus.pix_de), 64'h1);
      tick();
    end
    chk("pf_line_done", 64'(bus.line_done), 64'h1);
    chk("pf_end_de", 64'(bus.pix_de), 64'h0);
    chk("pf_end_data", 64'(bus.pix_data), 64'h10);
    tick();
    chk("pf_done_pulse", 64'(bus.line_done), 64'h0);

    // line_len=3 -> zero effective length, H untouched
    bus.s_data = 64'h0123_4567_89AB_CDEF; bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    bus.line_len = 12'd3; bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    chk("l3_line_done", 64'(bus.line_done), 64'h1);
    chk("l3_de", 64'(bus.pix_de), 64'h0);
    chk("l3_s_ready", 64'(bus.s_ready), 64'h0);
    tick();
    chk("l3_done_pulse", 64'(bus.line_done), 64'h0);
    chk("l3_still_idle", 64'(bus.pix_de), 64'h0);

    // line_len=7 -> 4 pixels, 8 bytes
    bus.line_len = 12'd7; bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("l7_byte%0d", i), 64'(bus.pix_data), 64'(l7_exp[i]));
      chk($sformatf("l7_de%0d", i), 64'(bus.pix_de), 64'h1);
      tick();
    end
    chk("l7_line_done", 64'(bus.line_done), 64'h1);
    chk("l7_no_byte8", 64'(bus.pix_de), 64'h0);
    tick();

    // Back-to-back lines: second line_start lands on the edge that ends the first
    bus.s_data = 64'hB7B6_B5B4_B3B2_B1B0; bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    bus.line_len = 12'd4; bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_a_byte%0d", i), 64'(bus.pix_data), 64'(8'hB0 + 8'(i)));
      chk($sformatf("b2b_a_de%0d", i), 64'(bus.pix_de), 64'h1);
      if (i == 0) begin
        bus.s_data = 64'hC7C6_C5C4_C3C2_C1C0; bus.s_valid = 1'b1;
      end
      if (i == 1) begin
        bus.s_valid = 1'b0;
        chk("b2b_refill", 64'(bus.s_ready), 64'h0);
      end
      if (i == 7) begin
        bus.line_len = 12'd5; bus.line_start = 1'b1;
      end
      tick();
    end
    bus.line_start = 1'b0;
    chk("b2b_line_done", 64'(bus.line_done), 64'h1);
    chk("b2b_b_byte0", 64'(bus.pix_data), 64'hC0);
    chk("b2b_b_de0", 64'(bus.pix_de), 64'h1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("b2b_b_byte%0d", i), 64'(bus.pix_data), 64'(8'hC0 + 8'(i)));
      chk($sformatf("b2b_b_de%0d", i), 64'(bus.pix_de), 64'h1);
    end
    tick();
    chk("b2b_b_line_done", 64'(bus.line_done), 64'h1);
    chk("b2b_b_end_de", 64'(bus.pix_de), 64'h0);
    tick();

    // Streaming 768 pixels with s_valid held high
    acc_cnt = 0; sk = 0; stream_on = 1'b1;
    bus.s_data = sym_f(0); bus.s_valid = 1'b1;
    tick();
    bus.line_len = 12'd768; bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    de_cnt = 0; errs = 0;
    for (int j = 0; j < 1536; j++) begin
      tmp  = sym_f(j / 8);
      expb = tmp[8*(j%8) +: 8];
      if (bus.pix_de === 1'b1) de_cnt++;
      if (bus.pix_data !== expb) errs++;
      tick();
    end
    chk("str_de_count", 64'(de_cnt), 64'd1536);
    chk("str_data_errs", 64'(errs), 64'd0);
    chk("str_line_done", 64'(bus.line_done), 64'h1);
    chk("str_end_de", 64'(bus.pix_de), 64'h0);
    chk("str_underflow", 64'(bus.underflow), 64'h0);
    chk("str_accepts", 64'(acc_cnt), 64'd193);
    chk("str_h_full", 64'(bus.s_ready), 64'h0);
    stream_on = 1'b0; bus.s_valid = 1'b0;
    tick();

    // Reset after byte 5 of a line, with H refilled
    bus.line_len = 12'd8; bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    bus.s_data = 64'hEEEE_EEEE_EEEE_EEEE; bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    chk("rml_h_full", 64'(bus.s_ready), 64'h0);
    repeat (4) tick();
    chk("rml_byte5_de", 64'(bus.pix_de), 64'h1);
    rst = 1'b1;
    #1;
    chk("rml_pix_data", 64'(bus.pix_data), 64'h10);
    chk("rml_pix_de", 64'(bus.pix_de), 64'h0);
    chk("rml_line_done", 64'(bus.line_done), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rml_s_ready", 64'(bus.s_ready), 64'h1);
    chk("rml_underflow", 64'(bus.underflow), 64'h0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.line_done !== 1'b0 || bus.pix_de !== 1'b0) bad++;
      tick();
    end
    chk("rml_no_done_no_de", 64'(bad), 64'd0);

    // Underflow: one symbol for an 8-pixel line; clear coincides with the set
    bus.s_data = 64'hD7D6_D5D4_D3D2_D1D0; bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    bus.line_len = 12'd8; bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("uf_byte%0d", i), 64'(bus.pix_data), 64'(8'hD0 + 8'(i)));
      chk($sformatf("uf_de%0d", i), 64'(bus.pix_de), 64'h1);
      if (i == 0) chk("uf_pre", 64'(bus.underflow), 64'h0);
      if (i == 7) bus.underflow_clr = 1'b1;
      tick();
    end
    bus.underflow_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) chk("uf_set_wins", 64'(bus.underflow), 64'h1);
      chk($sformatf("uf_blank%0d", i), 64'(bus.pix_data), (i % 2 == 0) ? 64'h80 : 64'h10);
      chk($sformatf("uf_blank_de%0d", i), 64'(bus.pix_de), 64'h0);
      tick();
    end
    chk("uf_line_done", 64'(bus.line_done), 64'h1);
    repeat (3) tick();
    chk("uf_sticky", 64'(bus.underflow), 64'h1);
    bus.underflow_clr = 1'b1;
    tick();
    bus.underflow_clr = 1'b0;
    chk("uf_cleared", 64'(bus.underflow), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
